// File: rtl/param_memory.sv
// Parametrised single-port synchronous RAM with req/ready handshake, registered read data and a clear engine.
// Optional macro PARITY_EN adds per-word even parity with parity_err output and inj_par test input.
module param_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
`ifdef PARITY_EN
  input  logic              inj_par,
  output logic              parity_err,
`endif
  output logic              ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] dout,
  output logic              busy_clr
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ready;
  logic                r_busy_clr;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_dout;
  logic                r_parity_err;
  logic [WORD_W-1:0]   r_mem [DEPTH];

  logic                w_acc;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [WORD_W-1:0]   w_wdata;
  logic [WORD_W-1:0]   w_rword;

  // r_ready is only ever high in IDLE, so it also gates out accesses during clear
  assign w_acc   = req & r_ready & ~clr;
  assign w_rword = r_mem[addr];

  // Write-port steering: the clear engine owns the port in CLEAR, accepted writes in IDLE
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = '0;
      end
      S_IDLE: begin
        if (w_acc && we) begin
          w_we    = 1'b1;
          w_waddr = addr;
`ifdef PARITY_EN
          w_wdata = {even_par(din) ^ inj_par, din};
`else
          w_wdata = din;
`endif
        end else begin
          w_we    = 1'b0;
        end
      end
      default: begin
        w_we    = 1'b0;
      end
    endcase
  end

  // Storage array; contents are zeroed by the clear engine rather than by reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Control FSM with registered handshake, read data and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CLEAR;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_busy_clr   <= 1'b1;
      r_rd_valid   <= 1'b0;
      r_dout       <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_rd_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_busy_clr <= 1'b0;
            r_cnt      <= '0;
          end else begin
            r_cnt      <= r_cnt + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (clr) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_busy_clr <= 1'b1;
          end else if (w_acc && !we) begin
            r_rd_valid   <= 1'b1;
            r_dout       <= w_rword[DATA_W-1:0];
            // XOR across data plus parity bit is 1 exactly when the stored parity is wrong
            r_parity_err <= ^w_rword;
          end else begin
            r_rd_valid   <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_CLEAR;
          r_cnt      <= '0;
          r_ready    <= 1'b0;
          r_busy_clr <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign rd_valid = r_rd_valid;
  assign dout     = r_dout;
  assign busy_clr = r_busy_clr;
`ifdef PARITY_EN
  assign parity_err = r_parity_err;
`else
  logic w_unused_par;
  assign w_unused_par = r_parity_err;
`endif

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
Parametrised single-port synchronous RAM; the next-generation replacement for the fixed 16x8 simple memory.
- Adds a req/ready handshake, registered read data qualified by rd_valid, and a hardware clear engine that zeroes the array after reset or on request.
- Sits behind bus/controller logic as a generic storage primitive; composite memories instantiate several of these.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  access request, sampled on rising edge of clk
- we  input  1  1 = write, 0 = read; qualified by req
- addr  input  ADDR_W  word address
- din  input  DATA_W  write data
- clr  input  1  request full-array clear
- ready  output  1  block can accept an access this cycle
- rd_valid  output  1  one-cycle pulse; dout holds new read data
- dout  output  DATA_W  registered read data; holds its value between reads
- busy_clr  output  1  clear engine active

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clear counter=0, ready=0, rd_valid=0, dout=0, busy_clr=1.
  - Array contents are not reset directly; the CLEAR state zeroes them.
- States: CLEAR, IDLE.
- CLEAR:
  - Each rising edge writes 0 to array[cnt], then cnt increments.
  - On the edge that writes address DEPTH-1: state goes to IDLE, ready=1, busy_clr=0, cnt=0.
  - Duration is exactly DEPTH edges after rst_n deasserts. For DEPTH=16, ready rises on the 16th edge.
  - req and clr are ignored while in CLEAR.
- IDLE: ready=1. Accept condition is acc = req & ready & ~clr.
  - Write (acc & we): array[addr] <= din on that edge. No rd_valid. dout is unchanged.
  - Read (acc & ~we): dout <= array[addr] and rd_valid=1 on that same edge, so data is visible one cycle after req is sampled. rd_valid deasserts on the next edge unless another read is accepted.
  - Back-to-back accesses are allowed every cycle; throughput is 1 access/cycle.
  - Read directly after write to the same address returns the newly written data.
- clr in IDLE:
  - On the edge clr=1 is sampled: state goes to CLEAR, cnt=0, ready=0, busy_clr=1.
  - A req in the same cycle is dropped: no write, no read, no rd_valid.
  - rd_valid from a read accepted in the previous cycle still pulses normally.
  - dout is not cleared by clr.
- Reset mid-operation:
  - rst_n low in any state immediately forces the reset values.
  - A partially completed clear restarts from address 0 after deassert.
  - In-flight rd_valid is killed.
- Address width: DEPTH is exactly 2**ADDR_W, so every address is in range. The clear counter is ADDR_W bits and its terminal value is all-ones.

Optional Feature:
Macro PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from din on write (clear writes data 0, parity 0).
  - Output parity_err (1 bit) asserts with rd_valid when the stored parity mismatches the XOR of the stored data. It resets to 0 and is 0 whenever rd_valid=0.
  - Input inj_par (1 bit) inverts the stored parity bit on an accepted write; it exists for test only.
- Not defined: no parity storage; ports parity_err and inj_par do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset then release, with req=1 held -> ready=0 for 16 edges; ready=1 after the 16th edge. Reads of addresses 0..15 then return 8'h00.
2. Write 8'hA5 to addr 1, then 8'h5A to addr 2 (consecutive cycles), then read addr 1 and addr 2 back-to-back -> rd_valid pulses on 2 consecutive cycles with dout=8'hA5 then 8'h5A. dout holds 8'h5A afterwards.
3. Write 8'h3C to addr 15, then read addr 15 the very next cycle -> dout=8'h3C, rd_valid=1 exactly one cycle.
4. Fill all 16 addresses, then assert clr with a write of 8'hFF to addr 0 in the same cycle -> write dropped; busy_clr=1 for 16 cycles, ready=0. Afterwards all addresses read 8'h00.
5. Pull rst_n low at clear cycle 7, release -> busy_clr remains high and ready rises only 16 edges after release; rd_valid=0, dout=0 during reset.
6. (PARITY_EN) Write 8'h01 to addr 3 with inj_par=1, write 8'h01 to addr 4 with inj_par=0, read both -> parity_err=1 for addr 3, 0 for addr 4; dout=8'h01 in both cases.
